// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg
//   Shared definitions for the SPI daisy-chain arbiter: the arbiter FSM
//   state type, default frame width / launch timeout, and a small index
//   wrap helper used by the rotating-priority logic.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    RESP      = 2'd3
  } arb_state_t;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_DW      = 8;
  localparam int DEF_TIMEOUT = 64;

  // Wraps an index that may exceed n-1 by less than n back into 0..n-1.
  function automatic int wrap_idx(input int i, input int n);
    return (i >= n) ? i - n : i;
  endfunction

endpackage

// File: rtl/spi_chain_arbiter_rr_pick.sv
// rr_pick
//   Combinational rotating-priority selector. Scans the request vector
//   starting at ptr and wrapping from NREQ-1 back to 0; the first set bit
//   wins.
// Ports
//   req     in   NREQ  request vector
//   ptr     in   IW    index with highest priority this round (< NREQ)
//   onehot  out  NREQ  one-hot winner, 0 when nothing requests
//   idx     out  IW    binary index of the winner, 0 when nothing requests
//   any     out  1     at least one request is set
module rr_pick
  import spi_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            any
);

  always_comb begin
    int pos;
    pos    = 0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      pos = wrap_idx(int'(ptr) + k, NREQ);
      if (!any && req[pos]) begin
        any         = 1'b1;
        onehot[pos] = 1'b1;
        idx         = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/spi_chain_arbiter.sv
// spi_chain_arbiter
//   Shares one SPI daisy-chain master among NREQ requesters. One requester
//   is granted per frame in round-robin order; the arbiter launches the
//   frame, waits for the master to finish shifting, and hands the returned
//   byte (or a timeout error) back to the owner with a one-cycle ack.
// Ports
//   clk       in   1        system clock, posedge
//   rst_n     in   1        synchronous reset, active low
//   req       in   NREQ     level requests, held until ack
//   req_din   in   NREQ*DW  packed frame data, slice i for req[i]
//   ack       out  NREQ     one-hot one-cycle completion pulse
//   rsp_dout  out  DW       returned byte, valid with ack
//   rsp_err   out  1        frame aborted by launch timeout, valid with ack
//   gnt       out  NREQ     one-hot current owner, 0 when idle
//   m_newd    out  1        start-frame request to the master
//   m_din     out  DW       frame data to the master
//   m_cs      in   1        master chip select, low during a frame
//   m_done    in   1        master frame-complete pulse
//   m_dout    in   DW       byte shifted out of the chain
module spi_chain_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_din,
  output logic [NREQ-1:0]    ack,
  output logic [DW-1:0]      rsp_dout,
  output logic               rsp_err,
  output logic [NREQ-1:0]    gnt,
  output logic               m_newd,
  output logic [DW-1:0]      m_din,
  input  logic               m_cs,
  input  logic               m_done,
  input  logic [DW-1:0]      m_dout
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_t state, state_next;

  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   gnt_idx;
  logic [CW-1:0]   tmo_cnt;
  logic [NREQ-1:0] pick_onehot;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            tmo_hit;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Last cycle the master may still hold cs high before the launch aborts.
  assign tmo_hit = (tmo_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // A new grant also needs m_cs high, so after a mid-frame reset the
  // arbiter cannot launch into a master that is still shifting.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (pick_any && m_cs) state_next = LAUNCH;
      LAUNCH:    if (!m_cs) state_next = WAIT_DONE;
                 else if (tmo_hit) state_next = RESP;
      WAIT_DONE: if (m_done) state_next = RESP;
      RESP:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    ack    = '0;
    m_newd = 1'b0;
    if (state == RESP)   ack    = gnt;
    if (state == LAUNCH) m_newd = 1'b1;
  end

  // Grant, frame data, timeout counter, response and rotation pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt      <= '0;
      gnt_idx  <= '0;
      m_din    <= '0;
      tmo_cnt  <= '0;
      rsp_dout <= '0;
      rsp_err  <= 1'b0;
      rr_ptr   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_any && m_cs) begin
            gnt     <= pick_onehot;
            gnt_idx <= pick_idx;
            m_din   <= req_din[int'(pick_idx)*DW +: DW];
            tmo_cnt <= '0;
          end
        end
        LAUNCH: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (m_cs && tmo_hit) rsp_err <= 1'b1;
        end
        WAIT_DONE: begin
          if (m_done) rsp_dout <= m_dout;
        end
        RESP: begin
          gnt      <= '0;
          rsp_dout <= '0;
          rsp_err  <= 1'b0;
          rr_ptr   <= IW'(wrap_idx(int'(gnt_idx) + 1, NREQ));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_chain_arbiter.sv
// tb_spi_chain_arbiter
//   Drives the arbiter with randomized requests against a small behavioural
//   daisy-chain master. Expected grant order comes from a round-robin model
//   and expected returned bytes from a model of the chain contents (the
//   chain returns the byte of the previous completed frame).
module tb_spi_chain_arbiter;

  localparam int NREQ    = 4;
  localparam int DW      = 8;
  localparam int TIMEOUT = 64;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*DW-1:0] req_din;
  logic [NREQ-1:0]    ack;
  logic [DW-1:0]      rsp_dout;
  logic               rsp_err;
  logic [NREQ-1:0]    gnt;
  logic               m_newd;
  logic [DW-1:0]      m_din;
  logic               m_cs;
  logic               m_done = 1'b0;
  logic [DW-1:0]      m_dout = '0;

  logic [DW-1:0] din [NREQ];
  assign req_din = {din[3], din[2], din[1], din[0]};

  spi_chain_arbiter #(
    .NREQ    (NREQ),
    .DW      (DW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_din  (req_din),
    .ack      (ack),
    .rsp_dout (rsp_dout),
    .rsp_err  (rsp_err),
    .gnt      (gnt),
    .m_newd   (m_newd),
    .m_din    (m_din),
    .m_cs     (m_cs),
    .m_done   (m_done),
    .m_dout   (m_dout)
  );

  always #5 clk = ~clk;

  // Behavioural daisy-chain master: a few cycles after newd it drops cs,
  // shifts for 2*DW cycles, then pulses done with the byte that was in the
  // chain and loads the new frame into the chain.
  logic          cs_stuck = 1'b0;
  logic          mst_cs = 1'b1;
  int            mphase = 0;
  int            mcnt = 0;
  logic [DW-1:0] mdata = '0;
  logic [DW-1:0] chain = 8'h3C;
  assign m_cs = cs_stuck ? 1'b1 : mst_cs;

  always @(posedge clk) begin
    m_done <= 1'b0;
    case (mphase)
      0: if (m_newd && !cs_stuck) begin
           mdata  <= m_din;
           mcnt   <= int'($urandom_range(0, 3));
           mphase <= 1;
         end
      1: if (mcnt == 0) begin
           mst_cs <= 1'b0;
           mcnt   <= 2 * DW;
           mphase <= 2;
         end else mcnt <= mcnt - 1;
      2: if (mcnt == 0) begin
           m_done <= 1'b1;
           m_dout <= chain;
           chain  <= mdata;
           mst_cs <= 1'b1;
           mphase <= 0;
         end else mcnt <= mcnt - 1;
      default: mphase <= 0;
    endcase
  end

  int tests = 0;
  int failed = 0;
  int proto_err = 0;
  int newd_cycles = 0;
  logic rereq = 1'b0;
  logic [NREQ-1:0] prev_ack = '0;
  int            ack_idx_q [$];
  logic [DW-1:0] ack_dout_q [$];
  logic          ack_err_q [$];

  // Reference model state: chain contents and round-robin pointer.
  logic [DW-1:0] chain_model = 8'h3C;
  int ptr_model = 0;

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int model_pick(input logic [NREQ-1:0] mask, input int p);
    for (int k = 0; k < NREQ; k++) if (mask[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  // One cycle: observe outputs at negedge, log acks, retire requests.
  task automatic step();
    @(negedge clk);
    if (m_newd) newd_cycles++;
    if (!$onehot0(ack) || !$onehot0(gnt)) proto_err++;
    if (ack != '0 && ack != gnt) proto_err++;
    if (ack != '0 && prev_ack != '0) proto_err++;
    if (ack != '0) begin
      ack_idx_q.push_back(oh_idx(ack));
      ack_dout_q.push_back(rsp_dout);
      ack_err_q.push_back(rsp_err);
      req = req & ~ack;
      if (rereq) req = req | ack;
    end
    prev_ack = ack;
  endtask

  task automatic wait_acks(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < bound; c++) begin
      if (ack_idx_q.size() >= n) break;
      step();
    end
    if (ack_idx_q.size() >= n) ok = 1'b1;
  endtask

  task automatic wait_cs_low(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (!m_cs) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    tests++; if (gnt !== '0) begin failed++; $display("[TB] FAIL reset_gnt got %h want 0", gnt); end
    tests++; if (ack !== '0) begin failed++; $display("[TB] FAIL reset_ack got %h want 0", ack); end
    tests++; if (rsp_dout !== '0) begin failed++; $display("[TB] FAIL reset_dout got %h want 0", rsp_dout); end
    tests++; if (rsp_err !== 1'b0) begin failed++; $display("[TB] FAIL reset_err got %b want 0", rsp_err); end
    tests++; if (m_newd !== 1'b0) begin failed++; $display("[TB] FAIL reset_newd got %b want 0", m_newd); end
    tests++; if (m_din !== '0) begin failed++; $display("[TB] FAIL reset_din got %h want 0", m_din); end
    rst_n = 1'b1;
    ptr_model = 0;
    step();
  endtask

  task automatic test_single();
    bit ok;
    int idx;
    logic [DW-1:0] d;
    logic e;
    for (int i = 0; i < NREQ; i++) din[i] = DW'($urandom);
    din[0] = 8'hA5;
    req = 4'b0001;
    step();
    tests++; if (m_newd !== 1'b1) begin failed++; $display("[TB] FAIL single_newd got %b want 1", m_newd); end
    tests++; if (m_din !== 8'hA5) begin failed++; $display("[TB] FAIL single_din got %h want a5", m_din); end
    wait_acks(1, 200, ok);
    tests++;
    if (!ok) begin
      failed++; $display("[TB] FAIL single_ack_timeout got none want 1 ack");
    end else begin
      idx = ack_idx_q.pop_front(); d = ack_dout_q.pop_front(); e = ack_err_q.pop_front();
      tests++; if (idx != 0) begin failed++; $display("[TB] FAIL single_idx got %0d want 0", idx); end
      tests++; if (d !== chain_model) begin failed++; $display("[TB] FAIL single_dout got %h want %h", d, chain_model); end
      tests++; if (e !== 1'b0) begin failed++; $display("[TB] FAIL single_err got %b want 0", e); end
    end
    chain_model = 8'hA5;
    ptr_model = 1;
    repeat (30) step();
    tests++; if (ack_idx_q.size() != 0) begin failed++; $display("[TB] FAIL single_extra_ack got %0d want 0", ack_idx_q.size()); void'(ack_idx_q.pop_front()); ack_dout_q.delete(); ack_err_q.delete(); ack_idx_q.delete(); end
  endtask

  // Serves frames until req drains (or max frames), checking each ack
  // against the round-robin and chain models.
  task automatic serve_and_check(input string name, input int max_frames, input int rereq_frames);
    bit ok;
    int exp_idx, idx;
    logic [DW-1:0] d;
    logic e;
    int f;
    f = 0;
    while (req != '0 && f < max_frames) begin
      rereq = (f < rereq_frames - 1);
      exp_idx = model_pick(req, ptr_model);
      wait_acks(1, 300, ok);
      tests++;
      if (!ok) begin
        failed++; $display("[TB] FAIL %s_ack_timeout frame %0d got none want ack", name, f);
        break;
      end
      idx = ack_idx_q.pop_front(); d = ack_dout_q.pop_front(); e = ack_err_q.pop_front();
      if (idx != exp_idx) begin failed++; $display("[TB] FAIL %s_idx frame %0d got %0d want %0d", name, f, idx, exp_idx); end
      tests++; if (d !== chain_model) begin failed++; $display("[TB] FAIL %s_dout frame %0d got %h want %h", name, f, d, chain_model); end
      tests++; if (e !== 1'b0) begin failed++; $display("[TB] FAIL %s_err frame %0d got %b want 0", name, f, e); end
      chain_model = din[exp_idx];
      ptr_model = (exp_idx + 1) % NREQ;
      f++;
    end
    rereq = 1'b0;
  endtask

  task automatic test_contention();
    for (int i = 0; i < NREQ; i++) din[i] = {4'(i + 1), 4'($urandom)};
    req = 4'b1111;
    serve_and_check("contention", 12, 6);
  endtask

  task automatic test_rotation();
    din[0] = DW'($urandom); din[2] = DW'($urandom);
    req = 4'b0001;
    serve_and_check("rot_first", 2, 0);
    tests++; if (ptr_model != 1) begin failed++; $display("[TB] FAIL rotation_setup got ptr %0d want 1", ptr_model); end
    req = 4'b0101;
    tests++; if (model_pick(req, ptr_model) != 2) begin failed++; $display("[TB] FAIL rotation_model got %0d want 2", model_pick(req, ptr_model)); end
    serve_and_check("rotation", 4, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NREQ; i++) din[i] = DW'($urandom);
      req = NREQ'($urandom_range(1, 15));
      serve_and_check("random", 8, 0);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int idx;
    logic [DW-1:0] d;
    logic e;
    cs_stuck = 1'b1;
    din[1] = DW'($urandom);
    newd_cycles = 0;
    req = 4'b0010;
    wait_acks(1, 200, ok);
    tests++;
    if (!ok) begin
      failed++; $display("[TB] FAIL timeout_ack got none want 1 ack");
    end else begin
      idx = ack_idx_q.pop_front(); d = ack_dout_q.pop_front(); e = ack_err_q.pop_front();
      tests++; if (idx != 1) begin failed++; $display("[TB] FAIL timeout_idx got %0d want 1", idx); end
      tests++; if (e !== 1'b1) begin failed++; $display("[TB] FAIL timeout_err got %b want 1", e); end
      tests++; if (d !== '0) begin failed++; $display("[TB] FAIL timeout_dout got %h want 0", d); end
    end
    tests++; if (newd_cycles != TIMEOUT) begin failed++; $display("[TB] FAIL timeout_newd_cycles got %0d want %0d", newd_cycles, TIMEOUT); end
    step();
    tests++; if (m_newd !== 1'b0) begin failed++; $display("[TB] FAIL timeout_newd_after got %b want 0", m_newd); end
    tests++; if (rsp_err !== 1'b0) begin failed++; $display("[TB] FAIL timeout_err_after got %b want 0", rsp_err); end
    ptr_model = 2;
    cs_stuck = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset_mid();
    bit ok, cs_seen, early;
    int j, idx;
    logic [DW-1:0] d;
    logic e;
    j = int'($urandom_range(0, NREQ - 1));
    din[j] = DW'($urandom);
    req = NREQ'(1 << j);
    wait_cs_low(ok);
    tests++; if (!ok) begin failed++; $display("[TB] FAIL resetmid_cs_low got cs high want low"); end
    step(); step();
    rst_n = 1'b0;
    step(); step();
    tests++; if ({gnt, ack, m_newd, rsp_err} !== '0) begin failed++; $display("[TB] FAIL resetmid_ctrl got gnt %h ack %h newd %b err %b want 0", gnt, ack, m_newd, rsp_err); end
    tests++; if ({rsp_dout, m_din} !== '0) begin failed++; $display("[TB] FAIL resetmid_data got dout %h din %h want 0", rsp_dout, m_din); end
    rst_n = 1'b1;
    ptr_model = 0;
    chain_model = din[j];
    cs_seen = 1'b0; early = 1'b0; ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (gnt != '0) begin
        if (!cs_seen) early = 1'b1;
        ok = 1'b1;
        break;
      end
      if (m_cs) cs_seen = 1'b1;
    end
    tests++; if (!ok || early) begin failed++; $display("[TB] FAIL resetmid_regrant got granted %b early %b want granted after cs high", ok, early); end
    tests++; if (ack_idx_q.size() != 0) begin failed++; $display("[TB] FAIL resetmid_no_ack got %0d acks want 0", ack_idx_q.size()); ack_idx_q.delete(); ack_dout_q.delete(); ack_err_q.delete(); end
    wait_acks(1, 200, ok);
    tests++;
    if (!ok) begin
      failed++; $display("[TB] FAIL resetmid_ack got none want 1 ack");
    end else begin
      idx = ack_idx_q.pop_front(); d = ack_dout_q.pop_front(); e = ack_err_q.pop_front();
      tests++; if (idx != j || e !== 1'b0) begin failed++; $display("[TB] FAIL resetmid_idx got %0d err %b want %0d err 0", idx, e, j); end
      tests++; if (d !== chain_model) begin failed++; $display("[TB] FAIL resetmid_dout got %h want %h", d, chain_model); end
    end
    ptr_model = (j + 1) % NREQ;
    repeat (3) step();
  endtask

  task automatic test_early_drop();
    bit ok;
    int idx;
    logic [DW-1:0] d;
    logic e;
    din[1] = DW'($urandom);
    req = 4'b0010;
    wait_cs_low(ok);
    tests++; if (!ok) begin failed++; $display("[TB] FAIL drop_cs_low got cs high want low"); end
    step();
    req[1] = 1'b0;
    wait_acks(1, 200, ok);
    tests++;
    if (!ok) begin
      failed++; $display("[TB] FAIL drop_ack got none want 1 ack");
    end else begin
      idx = ack_idx_q.pop_front(); d = ack_dout_q.pop_front(); e = ack_err_q.pop_front();
      tests++; if (idx != 1 || e !== 1'b0) begin failed++; $display("[TB] FAIL drop_idx got %0d err %b want 1 err 0", idx, e); end
      tests++; if (d !== chain_model) begin failed++; $display("[TB] FAIL drop_dout got %h want %h", d, chain_model); end
    end
    chain_model = din[1];
    ptr_model = 2;
    repeat (40) step();
    tests++; if (ack_idx_q.size() != 0) begin failed++; $display("[TB] FAIL drop_extra_ack got %0d want 0", ack_idx_q.size()); ack_idx_q.delete(); ack_dout_q.delete(); ack_err_q.delete(); end
  endtask

  task automatic test_protocol();
    tests++;
    if (proto_err != 0) begin failed++; $display("[TB] FAIL protocol got %0d violations want 0", proto_err); end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) din[i] = '0;
    test_reset();
    test_single();
    test_contention();
    test_rotation();
    test_random();
    test_timeout();
    test_reset_mid();
    test_early_drop();
    test_random();
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got no finish want finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule
